// File: rtl/typing_display_ctrl.sv
// typing_display_ctrl: round FSM, countdown, saturating score and display scheduling for the typing game
module typing_display_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int ROUND_SECS = 60,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic [7:0] target,
  output logic [7:0] time_res,
  output logic       time_clr,
  output logic [7:0] main_res,
  output logic       main_clr,
  output logic [7:0] score,
  output logic       game_over
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] SECS = 8'(ROUND_SECS);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  state_t state, state_nxt;
  logic [7:0] time_left;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] blink_cnt;
  logic blink_ph, tick, last, restart, up, dn, blink_wrap;
  always_comb begin
    tick = state == PLAY && div_cnt == DW'(TICK_DIV - 1);
    last = tick && time_left == 8'd1;
    restart = start && (state == IDLE || state == OVER);
    up = state == PLAY && hit && !miss && score != 8'hFF;
    dn = state == PLAY && miss && !hit && score != 8'h00;
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    state_nxt = state == IDLE ? (start ? PLAY : IDLE) :
                state == PLAY ? (last ? OVER : PLAY) :
                state == OVER ? (start ? PLAY : OVER) : IDLE;
    time_res = state == PLAY ? time_left : state == OVER ? 8'd0 : SECS;
    time_clr = 1'b0;
    main_res = state == PLAY ? target : state == OVER ? score : 8'd0;
    main_clr = state == PLAY ? 1'b0 : state == OVER ? blink_ph : 1'b1;
    game_over = state == OVER;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= 8'd0;
      time_left <= SECS;
      div_cnt <= '0;
      blink_cnt <= '0;
      blink_ph <= 1'b0;
    end else begin
      if (restart) begin
        time_left <= SECS;
        score <= 8'd0;
        div_cnt <= '0;
      end else if (state == PLAY) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) time_left <= time_left - 8'd1;
        score <= up ? score + 8'd1 : dn ? score - 8'd1 : score;
      end
      // blink phase restarts on every entry into OVER so the first half-period is always shown
      if (last) begin
        blink_cnt <= '0;
        blink_ph <= 1'b0;
      end else if (state == OVER) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        if (blink_wrap) blink_ph <= ~blink_ph;
      end
    end
  end
endmodule

// File: tb/tb_typing_display_ctrl.sv
// tb_typing_display_ctrl: scoreboard-driven directed bench for typing_display_ctrl
module tb_typing_display_ctrl;
  localparam int TD = 4, RS = 3, BD = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] time_res, main_res, score;
  logic time_clr, main_clr, game_over;
  logic start2 = 1'b0, hit2 = 1'b0;
  logic [7:0] time_res2, main_res2, score2;
  logic time_clr2, main_clr2, game_over2;
  typedef struct {string tag; logic [7:0] val;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int model;
  logic pat [0:5];
  logic hs [0:8];
  logic ms [0:8];

  typing_display_ctrl #(.TICK_DIV(TD), .ROUND_SECS(RS), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .miss(miss), .target(target),
    .time_res(time_res), .time_clr(time_clr), .main_res(main_res), .main_clr(main_clr),
    .score(score), .game_over(game_over));

  typing_display_ctrl #(.TICK_DIV(200), .ROUND_SECS(3), .BLINK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .hit(hit2), .miss(1'b0), .target(8'h00),
    .time_res(time_res2), .time_clr(time_clr2), .main_res(main_res2), .main_clr(main_clr2),
    .score(score2), .game_over(game_over2));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    hs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ms = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    repeat (2) cyc();
    rst_n = 1'b1;
    push("rst_time", 8'd3); push("rst_tclr", 8'd0); push("rst_main", 8'd0);
    push("rst_mclr", 8'd1); push("rst_score", 8'd0); push("rst_go", 8'd0);
    cyc();
    pop_chk(time_res); pop_chk(time_clr); pop_chk(main_res);
    pop_chk(main_clr); pop_chk(score); pop_chk(game_over);
    push("idle_time", 8'd3); push("idle_mclr", 8'd1);
    cyc();
    pop_chk(time_res); pop_chk(main_clr);
    target = 8'h41;
    start = 1'b1;
    push("play_time", 8'd3); push("play_go", 8'd0); push("play_main", 8'h41); push("play_mclr", 8'd0);
    cyc();
    start = 1'b0;
    pop_chk(time_res); pop_chk(game_over); pop_chk(main_res); pop_chk(main_clr);
    for (int k = 1; k <= 12; k++) begin
      start = (k == 2);
      hit = (k == 12);
      if (k % 4 == 0) push($sformatf("tick%0d_time", k), 8'(RS - k / 4));
      if (k == 12) begin
        push("over_go", 8'd1);
        push("final_tick_hit", 8'd1);
      end
      cyc();
      if (k % 4 == 0) pop_chk(time_res);
      if (k == 12) begin
        pop_chk(game_over);
        pop_chk(score);
      end
    end
    start = 1'b0;
    hit = 1'b0;
    push("blink0", 8'd0); push("over_main", 8'd1);
    pop_chk(main_clr); pop_chk(main_res);
    for (int i = 1; i <= 5; i++) begin
      hit = 1'b1;
      push($sformatf("blink%0d", i), 8'(pat[i]));
      push($sformatf("over_score%0d", i), 8'd1);
      cyc();
      pop_chk(main_clr); pop_chk(score);
    end
    hit = 1'b0;
    start = 1'b1;
    push("restart_score", 8'd0); push("restart_time", 8'd3); push("restart_go", 8'd0);
    cyc();
    start = 1'b0;
    pop_chk(score); pop_chk(time_res); pop_chk(game_over);
    model = 0;
    for (int i = 0; i < 9; i++) begin
      hit = hs[i];
      miss = ms[i];
      if (hit && !miss) model = model == 255 ? 255 : model + 1;
      else if (miss && !hit) model = model == 0 ? 0 : model - 1;
      push($sformatf("score_step%0d", i), 8'(model));
      cyc();
      pop_chk(score);
    end
    hit = 1'b0;
    miss = 1'b0;
    push("score_final", 8'd3); push("play_target", 8'h41); push("play_mclr2", 8'd0);
    pop_chk(score); pop_chk(main_res); pop_chk(main_clr);
    #2 rst_n = 1'b0;
    push("arst_time", 8'd3); push("arst_main", 8'd0); push("arst_mclr", 8'd1);
    push("arst_score", 8'd0); push("arst_go", 8'd0);
    #1;
    pop_chk(time_res); pop_chk(main_res); pop_chk(main_clr); pop_chk(score); pop_chk(game_over);
    #3 rst_n = 1'b1;
    push("post_rst_time", 8'd3); push("post_rst_mclr", 8'd1); push("post_rst_go", 8'd0);
    repeat (3) cyc();
    pop_chk(time_res); pop_chk(main_clr); pop_chk(game_over);
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    hit2 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      if (i == 254) push("sat_254", 8'hFE);
      if (i == 300) begin
        push("sat_ff", 8'hFF);
        push("sat_go", 8'd0);
      end
      cyc();
      if (i == 254) pop_chk(score2);
      if (i == 300) begin
        pop_chk(score2);
        pop_chk(game_over2);
      end
    end
    hit2 = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
